pair_pattern_sequencer: RTL and testbench
=========================================

// Module: pair_pattern_sequencer
// PURPOSE
//   Playback controller for the two-input (x1,x2) sequence detector.
//   Holds a small programmable pattern RAM of 2-bit symbols, drives one symbol per cycle
//   into the detector, and controls the detector's reset. Counts detector z pulses and
//   reports the first-hit index, so the detector runs self-checked in-system without a bench.
// PARAMETERS
//   DEPTH     16  pattern RAM entries (power of 2)
//   AW        4   address width, log2(DEPTH)
//   CNT_W     8   hit counter width
//   DRAIN_CYC 2   neutral cycles driven after last symbol before completion (>=1)
// PORTS
//   clk            in   1      system clock, rising edge
//   rst_n          in   1      asynchronous, active-low reset
//   wr_en          in   1      pattern RAM write strobe (honoured only when busy=0)
//   wr_addr        in   AW     pattern RAM write address
//   wr_data        in   2      symbol {x1,x2}
//   len            in   AW+1   symbols to play, legal 1..DEPTH, sampled with start
//   start          in   1      begin playback (honoured only in IDLE)
//   abort          in   1      terminate playback, return to IDLE
//   z_in           in   1      detector output
//   x1, x2         out  1      registered symbol to detector
//   det_rst_n      out  1      registered active-low reset to detector
//   busy           out  1      high in RUN and DRAIN
//   done           out  1      one-cycle pulse on normal completion
//   err            out  1      one-cycle pulse: start with illegal len
//   hit_count      out  CNT_W  z_in-high cycles seen in last run, saturating
//   hit_seen       out  1      at least one hit in last run
//   first_hit_idx  out  AW     symbol index on x1/x2 when first hit was sampled
// BEHAVIOUR
//   Reset: state=IDLE, x1=x2=0, det_rst_n=0, busy=done=err=0, hit_count=0, hit_seen=0,
//     first_hit_idx=0. Reset does not clear RAM contents (contents undefined after power-up).
//   States: IDLE, RUN, DRAIN, DONE. All outputs are registered.
//   IDLE: det_rst_n=0, x1=x2=0. wr_en writes RAM[wr_addr] at the edge.
//     start && 1<=len<=DEPTH -> RUN: capture len, idx=0, clear hit_count/hit_seen/first_hit_idx,
//     det_rst_n=1, {x1,x2}=RAM[0], busy=1.
//     start with len=0 or len>DEPTH -> err=1 for one cycle, stay IDLE, results unchanged.
//     wr_en and start at the same edge: the write commits and is visible to playback.
//   RUN: each edge idx++, {x1,x2}=RAM[idx]. Each symbol is held exactly one cycle.
//     When idx=len-1 at an edge -> DRAIN, {x1,x2}=00, drain counter=DRAIN_CYC-1.
//   DRAIN: holds 00; counter decrements each edge; at 0 -> DONE.
//   DONE: done=1, busy=0, det_rst_n=0 for one cycle -> IDLE.
//   Hit capture: in every RUN/DRAIN cycle with z_in=1, hit_count++ (saturates at 2^CNT_W-1).
//     The first such cycle sets hit_seen=1 and first_hit_idx=idx. In DRAIN, idx holds len-1.
//   Results hold from DONE until the next accepted start.
//   abort in RUN/DRAIN -> IDLE next edge: det_rst_n=0, x=00, busy=0, no done pulse,
//     hit results keep their partial values. abort in IDLE/DONE is ignored.
//     abort together with start in IDLE: abort is ignored and start is honoured.
//   wr_en while busy=1 is dropped. start while busy=1 is ignored.
//   Async reset mid-run: immediate return to reset values.
//   Run length = len + DRAIN_CYC cycles with busy=1; done follows on the next cycle.
// TESTING
//   1. Reset -> all outputs at reset values; det_rst_n=0; start with len=0 -> err pulse, busy stays 0.
//   2. Load RAM[0..3]=01,10,11,00; start len=4 -> x1x2 = 01,10,11,00, then 00,00;
//      busy high for 6 cycles; done pulse on cycle 7.
//   3. Same run with z_in forced 1 on the RAM[2] cycle only -> hit_count=1, hit_seen=1,
//      first_hit_idx=2.
//   4. z_in held 1 for a len=16 run with CNT_W=4 -> hit_count saturates at 15.
//   5. abort on the 3rd RUN cycle -> next cycle IDLE, det_rst_n=0, no done; wr_en during RUN
//      -> RAM unchanged, verified by a replay.
//   6. start with len=17 -> err pulse; start pulse during RUN -> ignored, run completes normally.

Source files
------------

// File: rtl/pair_pattern_sequencer.sv
// Pattern playback controller for a two-input (x1,x2) sequence detector: plays a
// programmable symbol list into the detector and records its hit statistics.
module pair_pattern_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [1:0]       wr_data,
  input  logic [AW:0]      len,
  input  logic             start,
  input  logic             abort,
  input  logic             z_in,
  output logic             x1,
  output logic             x2,
  output logic             det_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_seen,
  output logic [AW-1:0]    first_hit_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int              DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [AW:0]     MAX_LEN    = (AW+1)'(DEPTH);
  localparam logic [DW-1:0]   DRAIN_INIT = DW'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]    mem [DEPTH];
  state_t        state;
  logic [AW-1:0] idx;
  logic [AW:0]   len_q;
  logic [DW-1:0] drain_cnt;

  logic [AW:0]   last;
  logic [AW-1:0] next_idx;
  logic          len_ok;
  logic          wr_ok;
  logic [1:0]    sym0;

  assign last     = len_q - (AW+1)'(1);
  assign next_idx = idx + AW'(1);
  assign len_ok   = (len != (AW+1)'(0)) && (len <= MAX_LEN);
  assign wr_ok    = wr_en && !busy;
  // A write to entry 0 on the start edge must be what the detector sees first.
  assign sym0     = (wr_ok && (wr_addr == AW'(0))) ? wr_data : mem[0];

  // Pattern RAM write port, closed while a run is in progress.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Playback state machine, hit capture and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      len_q         <= '0;
      drain_cnt     <= '0;
      x1            <= 1'b0;
      x2            <= 1'b0;
      det_rst_n     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      hit_count     <= '0;
      hit_seen      <= 1'b0;
      first_hit_idx <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (((state == RUN) || (state == DRAIN)) && z_in) begin
        if (hit_count != CNT_MAX) begin
          hit_count <= hit_count + CNT_W'(1);
        end
        if (!hit_seen) begin
          hit_seen      <= 1'b1;
          first_hit_idx <= idx;
        end
      end

      case (state)
        IDLE: begin
          x1        <= 1'b0;
          x2        <= 1'b0;
          det_rst_n <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            if (len_ok) begin
              state         <= RUN;
              len_q         <= len;
              idx           <= '0;
              hit_count     <= '0;
              hit_seen      <= 1'b0;
              first_hit_idx <= '0;
              det_rst_n     <= 1'b1;
              {x1, x2}      <= sym0;
              busy          <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            {x1, x2}  <= 2'b00;
            det_rst_n <= 1'b0;
            busy      <= 1'b0;
          end else if ({1'b0, idx} == last) begin
            state     <= DRAIN;
            {x1, x2}  <= 2'b00;
            drain_cnt <= DRAIN_INIT;
          end else begin
            idx      <= next_idx;
            {x1, x2} <= mem[next_idx];
          end
        end
        DRAIN: begin
          if (abort) begin
            state     <= IDLE;
            {x1, x2}  <= 2'b00;
            det_rst_n <= 1'b0;
            busy      <= 1'b0;
          end else if (drain_cnt == DW'(0)) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            det_rst_n <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          {x1, x2}  <= 2'b00;
          det_rst_n <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_pattern_sequencer.sv
// Directed, table-driven bench for pair_pattern_sequencer (hit counter built 4 bits wide
// so saturation is reachable within one 16-symbol run).
module tb_pair_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [1:0] wr_data = 2'd0;
  logic [4:0] len = 5'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       z_in = 1'b0;
  logic       x1, x2, det_rst_n, busy, done, err, hit_seen;
  logic [3:0] hit_count;
  logic [3:0] first_hit_idx;

  int n_pass = 0;
  int n_total = 0;

  pair_pattern_sequencer #(.DEPTH(16), .AW(4), .CNT_W(4), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .abort(abort), .z_in(z_in),
    .x1(x1), .x2(x2), .det_rst_n(det_rst_n), .busy(busy), .done(done), .err(err),
    .hit_count(hit_count), .hit_seen(hit_seen), .first_hit_idx(first_hit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [1:0] wr_data;
    logic [4:0] len;
    logic       start;
    logic       abort;
    logic       z;
    logic [1:0] ex;
    logic       edrst;
    logic       ebusy;
    logic       edone;
    logic       eerr;
  } vec_t;

  vec_t tab[12];

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [1:0] wd,
                              input logic [4:0] l, input logic st, input logic ab, input logic z,
                              input logic [1:0] ex, input logic edrst, input logic ebusy,
                              input logic edone, input logic eerr);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.len = l; v.start = st; v.abort = ab;
    v.z = z; v.ex = ex; v.edrst = edrst; v.ebusy = ebusy; v.edone = edone; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; start = 1'b0; abort = 1'b0; z_in = 1'b0; len = 5'd0;
  endtask

  initial begin
    int busy_cyc;
    int done_cnt;
    logic [1:0] exp_sym [4];

    // Table: err on len=0, RAM load (entry 0 written on the start edge), a len=4 run
    // with z on the RAM[2] cycle, a start ignored in RUN and a write dropped in DRAIN.
    tab[0]  = mk(1'b0, 4'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    tab[1]  = mk(1'b1, 4'd3, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[2]  = mk(1'b1, 4'd2, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[3]  = mk(1'b1, 4'd1, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[4]  = mk(1'b1, 4'd0, 2'b01, 5'd4, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    tab[5]  = mk(1'b0, 4'd0, 2'b00, 5'd2, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    tab[6]  = mk(1'b0, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    tab[7]  = mk(1'b0, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tab[8]  = mk(1'b0, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tab[9]  = mk(1'b1, 4'd1, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tab[10] = mk(1'b0, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    tab[11] = mk(1'b0, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset values
    #12;
    chk("rst_x", {30'd0, x1, x2}, 32'd0);
    chk("rst_det_rst_n", {31'd0, det_rst_n}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_hits", {23'd0, hit_count, hit_seen, first_hit_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      wr_en = tab[i].wr_en; wr_addr = tab[i].wr_addr; wr_data = tab[i].wr_data;
      len = tab[i].len; start = tab[i].start; abort = tab[i].abort; z_in = tab[i].z;
      tick();
      chk($sformatf("v%0d_x", i), {30'd0, x1, x2}, {30'd0, tab[i].ex});
      chk($sformatf("v%0d_det_rst_n", i), {31'd0, det_rst_n}, {31'd0, tab[i].edrst});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tab[i].ebusy});
      chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tab[i].edone});
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, tab[i].eerr});
    end
    idle_inputs();
    chk("hit_count_single", {28'd0, hit_count}, 32'd1);
    chk("hit_seen_single", {31'd0, hit_seen}, 32'd1);
    chk("first_hit_idx_single", {28'd0, first_hit_idx}, 32'd2);

    // len=17 is illegal: err pulse, stay idle, results untouched
    len = 5'd17; start = 1'b1;
    tick();
    idle_inputs();
    chk("len17_err", {31'd0, err}, 32'd1);
    chk("len17_busy", {31'd0, busy}, 32'd0);
    chk("len17_hits_kept", {28'd0, hit_count}, 32'd1);
    tick();
    chk("err_one_cycle", {31'd0, err}, 32'd0);

    // Full-depth run with z held high: 18 busy cycles, counter saturates at 15
    len = 5'd16; start = 1'b1; z_in = 1'b1;
    tick();
    start = 1'b0;
    busy_cyc = busy ? 1 : 0;
    for (int n = 0; n < 40 && busy; n++) begin
      tick();
      if (busy) busy_cyc++;
    end
    chk("sat_busy_cycles", busy_cyc, 32'd18);
    chk("sat_done", {31'd0, done}, 32'd1);
    idle_inputs();
    tick();
    chk("sat_hit_count", {28'd0, hit_count}, 32'd15);
    chk("sat_hit_seen", {31'd0, hit_seen}, 32'd1);
    chk("sat_first_idx", {28'd0, first_hit_idx}, 32'd0);

    // Abort on the third RUN cycle
    len = 5'd4; start = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    chk("abort_pre_x", {30'd0, x1, x2}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_det_rst_n", {31'd0, det_rst_n}, 32'd0);
    chk("abort_x", {30'd0, x1, x2}, 32'd0);
    chk("abort_hits_cleared", {27'd0, hit_count, hit_seen}, 32'd0);
    done_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("abort_no_done", done_cnt, 32'd0);

    // Replay: the write issued during the earlier run must not have landed
    exp_sym[0] = 2'b01; exp_sym[1] = 2'b10; exp_sym[2] = 2'b11; exp_sym[3] = 2'b00;
    len = 5'd4; start = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("replay_sym%0d", k), {30'd0, x1, x2}, {30'd0, exp_sym[k]});
      tick();
    end
    done_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("replay_done_once", done_cnt, 32'd1);

    // Asynchronous reset in the middle of a run
    len = 5'd4; start = 1'b1;
    tick();
    idle_inputs();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_det_x", {29'd0, det_rst_n, x1, x2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
